hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

- Issue/hazard controller for the ID→EX boundary of the pipeline.
- Decides each cycle whether the decoded instruction may enter ID/EX, and tracks one in-flight multi-cycle multiply.
- Reserves the single register-file write port for the multiply's writeback.
- Produces the registered forwarding selects consumed by the EX-stage operand muxes.

## Interface
Parameters:
- REG_W, 3, register address width
- MUL_LAT, 3, cycles from multiply issue to multiply writeback; legal range 3..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decoded instruction present in ID
- id_ready  out  1  combinational; ID instruction may issue this cycle
- id_src1, id_src2  in  REG_W  source register addresses
- id_dst  in  REG_W  destination register
- id_regwrite  in  1  instruction writes id_dst
- id_is_mul  in  1  instruction is a multiply (multi-cycle unit)
- ex_valid  out  1  registered; EX holds a real instruction (0 = bubble)
- fwd_a, fwd_b  out  2  registered operand select: 0 regfile, 1 from EX/WB ALU result, 2 from multiply result
- mul_start  out  1  registered pulse; multiply unit loads operands
- mul_wb  out  1  multiply owns the write port this cycle
- mul_wb_dst  out  REG_W  destination for mul_wb
- stall_count  out  16  see Configuration

## Operation
- Issue happens on `issue = id_valid & id_ready`. At the next edge:
  - ex_valid ← issue.
  - fwd_a / fwd_b are computed and loaded.
  - The issued instruction's dst/regwrite/is_mul become the "last issued" record.
- No issue means a bubble: ex_valid ← 0, and the last-issued record is cleared (regwrite ← 0).
- Forward select for src s, evaluated at issue:
  - 2 if the multiply is pending with cnt==1 and mul_dst==s.
  - Otherwise 1 if last-issued is a valid non-mul with regwrite and dst==s.
  - Otherwise 0.
  - Priority is 2 > 1.
- States:
  - IDLE → BUSY on a mul issue. mul_dst ← id_dst, mul_we ← id_regwrite, cnt ← MUL_LAT-1.
  - BUSY: cnt decrements each cycle. mul_wb = mul_we when cnt==0.
  - BUSY exit at cnt==0: to IDLE, or reload (stay BUSY, cnt ← MUL_LAT-1) if a mul issues in that same cycle.
- id_ready = 0 (in BUSY) when any of these holds:
  - id_is_mul and cnt!=0 (structural).
  - mul_we and (id_src1==mul_dst or id_src2==mul_dst) and cnt>=2 (RAW).
  - id_regwrite and cnt==2 (write-port conflict: the ALU op would write in the same cycle as mul_wb).
  - id_regwrite and id_dst==mul_dst and mul_we and cnt>=2 (WAW).
- In IDLE, id_ready = 1.
- mul_start ← 1 for exactly one cycle after a mul issue.
- A multiply with id_regwrite=0 still occupies the unit, but never asserts mul_wb or blocks on RAW/WAW.

## Timing
- Reset values: ex_valid=0, fwd_a=fwd_b=0, mul_start=0, mul_wb=0, mul_wb_dst=0, state IDLE, cnt=0, last-issued cleared, stall_count=0.
- Reset mid-multiply: the pending multiply is discarded and mul_wb never asserts.
- Cycle numbering: ALU issued in cycle k → in EX during k+1 → writes during k+2.
- Mul issued in cycle 0 → mul_start in cycle 1 → mul_wb in cycle MUL_LAT.
- A dependent of the mul issues at the earliest in cycle MUL_LAT-1, with fwd=2.
- id_ready depends only on current state and ID fields, not on id_valid.

## Configuration
- HAZ_STATS_EN defined:
  - stall_count increments each cycle with id_valid & ~id_ready.
  - Saturates at 16'hFFFF; cleared by rst.
- HAZ_STATS_EN undefined: stall_count is tied to 0 and no counter logic exists.

## Structure
- Shared package: fwd select encodings (FWD_RF=0, FWD_ALU=1, FWD_MUL=2) and state encodings (IDLE, BUSY).
- One sub-module, mul_tracker: state, cnt, mul_dst, mul_we, mul_wb/mul_wb_dst.
- Top level keeps issue logic, last-issued record, forwarding and stall counter.

## Test plan
- Reset, then ALU r1←, then ALU using r1 back-to-back → both issue, second gets fwd_a=1.
- Mul r2← at cycle 0 (MUL_LAT=3), then ALU src r2 held valid → id_ready low in cycle 1, issues cycle 2 with fwd=2, mul_wb=1 with mul_wb_dst=2 in cycle 3.
- Mul r2← at cycle 0, ALU r5← (independent) in cycle 1 → blocked (cnt==2 port conflict), issues cycle 2; no cycle has two writers.
- Mul at cycle 0, mul in cycle 1 → blocked; mul in cycle 3 (cnt==0) → issues, mul_wb still pulses cycle 3, second mul_wb in cycle 6.
- rst asserted in cycle 1 of a multiply → all outputs 0 next cycle, no mul_wb ever, id_ready=1.
- With HAZ_STATS_EN, 5 blocked cycles → stall_count=5; without it, always 0.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler_pkg
// Brief    : Shared forwarding-select and multiply-tracker state encodings.
// Revision : 1.0
// ============================================================================
package hazard_scheduler_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_MUL = 2'd2;

    // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // Multiply result wins over the ALU bypass when both match.
    function automatic logic [1:0] fwd_select(input logic mul_hit, input logic alu_hit);
        if (mul_hit) begin
            return FWD_MUL;
        end else if (alu_hit) begin
            return FWD_ALU;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scheduler_mul_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler_mul_tracker
// Brief    : Tracks the single in-flight multiply and drives its writeback.
// Revision : 1.0
// ============================================================================
module hazard_scheduler_mul_tracker
    import hazard_scheduler_pkg::*;
#(
    parameter int REG_W   = 3,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_issue,
    input  logic [REG_W-1:0] issue_dst,
    input  logic             issue_we,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic [REG_W-1:0] mul_dst,
    output logic             mul_we,
    output logic             mul_wb,
    output logic [REG_W-1:0] mul_wb_dst
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MUL_LAT - 1);

    mul_state_t       state;
    mul_state_t       state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [REG_W-1:0] dst_nx;
    logic             we_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mul_dst <= '0;
            mul_we  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mul_dst <= dst_nx;
            mul_we  <= we_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dst_nx   = mul_dst;
        we_nx    = mul_we;
        case (state)
            IDLE: begin
                if (mul_issue) begin
                    state_nx = BUSY;
                    cnt_nx   = RELOAD;
                    dst_nx   = issue_dst;
                    we_nx    = issue_we;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    // A multiply issuing in the writeback cycle chains straight in.
                    if (mul_issue) begin
                        cnt_nx = RELOAD;
                        dst_nx = issue_dst;
                        we_nx  = issue_we;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state == BUSY);
    assign mul_wb     = busy && (cnt == '0) && mul_we;
    assign mul_wb_dst = mul_wb ? mul_dst : '0;

endmodule
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler
// Brief    : ID->EX issue/hazard control, forwarding selects, multiply tracking.
//            Define HAZ_STATS_EN to build the saturating stall counter.
// Revision : 1.0
// ============================================================================
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int REG_W   = 3,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_is_mul,
    output logic             ex_valid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mul_start,
    output logic             mul_wb,
    output logic [REG_W-1:0] mul_wb_dst,
    output logic [15:0]      stall_count
);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [REG_W-1:0] mul_dst;
    logic             mul_we;

    logic             issue;
    logic             hazard;
    logic             mul_hit_a;
    logic             mul_hit_b;
    logic             alu_hit_a;
    logic             alu_hit_b;

    logic [REG_W-1:0] last_dst;
    logic             last_regwrite;
    logic             last_is_mul;

    hazard_scheduler_mul_tracker #(
        .REG_W   (REG_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul_tracker (
        .clk        (clk),
        .rst        (rst),
        .mul_issue  (issue && id_is_mul),
        .issue_dst  (id_dst),
        .issue_we   (id_regwrite),
        .busy       (busy),
        .cnt        (cnt),
        .mul_dst    (mul_dst),
        .mul_we     (mul_we),
        .mul_wb     (mul_wb),
        .mul_wb_dst (mul_wb_dst)
    );

    // cnt==2 is the issue slot whose ALU writeback would collide with mul_wb.
    always_comb begin
        hazard = 1'b0;
        if (id_is_mul && (cnt != '0)) begin
            hazard = 1'b1;
        end
        if (mul_we && ((id_src1 == mul_dst) || (id_src2 == mul_dst)) && (cnt >= CNT_W'(2))) begin
            hazard = 1'b1;
        end
        if (id_regwrite && (cnt == CNT_W'(2))) begin
            hazard = 1'b1;
        end
        if (id_regwrite && (id_dst == mul_dst) && mul_we && (cnt >= CNT_W'(2))) begin
            hazard = 1'b1;
        end
    end

    assign id_ready = !busy || !hazard;
    assign issue    = id_valid && id_ready;

    assign mul_hit_a = busy && (cnt == CNT_W'(1)) && (mul_dst == id_src1);
    assign mul_hit_b = busy && (cnt == CNT_W'(1)) && (mul_dst == id_src2);
    assign alu_hit_a = last_regwrite && !last_is_mul && (last_dst == id_src1);
    assign alu_hit_b = last_regwrite && !last_is_mul && (last_dst == id_src2);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            mul_start     <= 1'b0;
            fwd_a         <= FWD_RF;
            fwd_b         <= FWD_RF;
            last_dst      <= '0;
            last_regwrite <= 1'b0;
            last_is_mul   <= 1'b0;
        end else begin
            ex_valid  <= issue;
            mul_start <= issue && id_is_mul;
            if (issue) begin
                fwd_a         <= fwd_select(mul_hit_a, alu_hit_a);
                fwd_b         <= fwd_select(mul_hit_b, alu_hit_b);
                last_dst      <= id_dst;
                last_regwrite <= id_regwrite;
                last_is_mul   <= id_is_mul;
            end else begin
                fwd_a         <= FWD_RF;
                fwd_b         <= FWD_RF;
                last_regwrite <= 1'b0;
                last_is_mul   <= 1'b0;
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scheduler
// Brief    : Directed scoreboard bench for hazard_scheduler (MUL_LAT=3).
// Revision : 1.0
// ============================================================================
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       id_ready;
    logic [2:0] id_src1;
    logic [2:0] id_src2;
    logic [2:0] id_dst;
    logic       id_regwrite;
    logic       id_is_mul;
    logic       ex_valid;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mul_start;
    logic       mul_wb;
    logic [2:0] mul_wb_dst;
    logic [15:0] stall_count;

    typedef struct packed {
        logic       v;
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
    } ex_exp_t;

    ex_exp_t exq[$];
    int total = 0;
    int bad = 0;
    int exp_stalls = 0;

    hazard_scheduler #(
        .REG_W   (3),
        .MUL_LAT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_is_mul   (id_is_mul),
        .ex_valid    (ex_valid),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .mul_start   (mul_start),
        .mul_wb      (mul_wb),
        .mul_wb_dst  (mul_wb_dst),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One ID cycle: drive, check combinational outputs, queue the EX expectation,
    // then retire it after the edge.
    task automatic step(input string tag, input logic v, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic rw, input logic ml, input logic rdy,
                        input logic [1:0] fa, input logic [1:0] fb, input logic wb,
                        input logic [2:0] wd);
        ex_exp_t e;
        ex_exp_t o;
        @(negedge clk);
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_dst      = d;
        id_regwrite = rw;
        id_is_mul   = ml;
        #1;
        check_val({tag, ".ready"}, 32'(id_ready), 32'(rdy));
        check_val({tag, ".wb"}, 32'(mul_wb), 32'(wb));
        if (wb) check_val({tag, ".wb_dst"}, 32'(mul_wb_dst), 32'(wd));
        if (v && !rdy) exp_stalls++;
        e.v  = v & rdy;
        e.st = v & rdy & ml;
        e.fa = fa;
        e.fb = fb;
        exq.push_back(e);
        @(posedge clk);
        #1;
        o = exq.pop_front();
        check_val({tag, ".ex_valid"}, 32'(ex_valid), 32'(o.v));
        check_val({tag, ".mul_start"}, 32'(mul_start), 32'(o.st));
        if (o.v) begin
            check_val({tag, ".fwd_a"}, 32'(fwd_a), 32'(o.fa));
            check_val({tag, ".fwd_b"}, 32'(fwd_b), 32'(o.fb));
        end
    endtask

    task automatic bubble(input string tag, input logic wb, input logic [2:0] wd);
        step(tag, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, wb, wd);
    endtask

    task automatic check_stalls(input string tag);
`ifdef HAZ_STATS_EN
        check_val(tag, 32'(stall_count), 32'(exp_stalls));
`else
        check_val(tag, 32'(stall_count), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_dst = '0;
        id_regwrite = 1'b0; id_is_mul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.ex_valid", 32'(ex_valid), 32'd0);
        check_val("rst.fwd_a", 32'(fwd_a), 32'd0);
        check_val("rst.fwd_b", 32'(fwd_b), 32'd0);
        check_val("rst.mul_start", 32'(mul_start), 32'd0);
        check_val("rst.mul_wb", 32'(mul_wb), 32'd0);
        check_val("rst.mul_wb_dst", 32'(mul_wb_dst), 32'd0);
        check_val("rst.stall", 32'(stall_count), 32'd0);
        check_val("rst.ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // ALU bypass on both operands; a bubble clears the last-issued record
        step("a0", 1, 3'd0, 3'd0, 3'd1, 1, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        step("a1", 1, 3'd1, 3'd3, 3'd4, 1, 0, 1, 2'd1, 2'd0, 0, 3'd0);
        step("a2", 1, 3'd5, 3'd4, 3'd6, 1, 0, 1, 2'd0, 2'd1, 0, 3'd0);
        bubble("a3", 0, 3'd0);
        step("a4", 1, 3'd6, 3'd4, 3'd7, 1, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        bubble("a5", 0, 3'd0);

        // RAW on multiply result: waits one cycle, then forwards from multiplier
        step("b0", 1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        step("b1", 1, 3'd2, 3'd0, 3'd6, 1, 0, 0, 2'd0, 2'd0, 0, 3'd0);
        step("b2", 1, 3'd2, 3'd0, 3'd6, 1, 0, 1, 2'd2, 2'd0, 0, 3'd0);
        bubble("b3", 1, 3'd2);
        bubble("b4", 0, 3'd0);

        // Independent ALU blocked only by the write-port slot
        step("c0", 1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        step("c1", 1, 3'd3, 3'd4, 3'd5, 1, 0, 0, 2'd0, 2'd0, 0, 3'd0);
        step("c2", 1, 3'd3, 3'd4, 3'd5, 1, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        bubble("c3", 1, 3'd2);
        bubble("c4", 0, 3'd0);

        // Back-to-back multiplies: second waits for cnt==0, then chains
        step("d0", 1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        step("d1", 1, 3'd0, 3'd0, 3'd3, 1, 1, 0, 2'd0, 2'd0, 0, 3'd0);
        step("d2", 1, 3'd0, 3'd0, 3'd3, 1, 1, 0, 2'd0, 2'd0, 0, 3'd0);
        step("d3", 1, 3'd0, 3'd0, 3'd3, 1, 1, 1, 2'd0, 2'd0, 1, 3'd2);
        bubble("d4", 0, 3'd0);
        bubble("d5", 0, 3'd0);
        bubble("d6", 1, 3'd3);
        bubble("d7", 0, 3'd0);

        // Non-writing consumer still honours RAW on the multiply destination
        step("g0", 1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        step("g1", 1, 3'd2, 3'd0, 3'd0, 0, 0, 0, 2'd0, 2'd0, 0, 3'd0);
        step("g2", 1, 3'd2, 3'd0, 3'd0, 0, 0, 1, 2'd2, 2'd0, 0, 3'd0);
        bubble("g3", 1, 3'd2);
        bubble("g4", 0, 3'd0);

        // Multiply without regwrite: no RAW/WAW blocking, never writes back
        step("f0", 1, 3'd0, 3'd0, 3'd2, 0, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        step("f1", 1, 3'd2, 3'd2, 3'd7, 0, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        step("f2", 1, 3'd0, 3'd1, 3'd2, 1, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        bubble("f3", 0, 3'd0);
        bubble("f4", 0, 3'd0);

        check_stalls("stall.after_hazards");

        // Reset in cycle 1 of a multiply discards it
        step("e0", 1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 2'd0, 2'd0, 0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_dst = '0;
        id_regwrite = 1'b0; id_is_mul = 1'b0;
        @(posedge clk);
        #1;
        exp_stalls = 0;
        check_val("e.rst.ex_valid", 32'(ex_valid), 32'd0);
        check_val("e.rst.mul_start", 32'(mul_start), 32'd0);
        check_val("e.rst.fwd_a", 32'(fwd_a), 32'd0);
        check_val("e.rst.mul_wb", 32'(mul_wb), 32'd0);
        check_val("e.rst.ready", 32'(id_ready), 32'd1);
        check_stalls("e.rst.stall");
        @(negedge clk);
        rst = 1'b0;
        step("e1", 1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 2'd0, 2'd0, 0, 3'd0);
        bubble("e2", 0, 3'd0);
        bubble("e3", 0, 3'd0);
        bubble("e4", 0, 3'd0);
        check_stalls("stall.final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
